// File: rtl/heartbeat_monitor.sv
// Receive-side heartbeat checker: synchronizes a pad heartbeat, measures the
// rise-to-rise period in clk cycles and reports alive / timeout / glitch.
module heartbeat_monitor #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 50000,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             alive,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             glitch,
    output logic [7:0]       edge_count
);

    // state  | meaning
    // IDLE   | no reference edge, counter parked at 0
    // ARMED  | one reference edge seen, measuring the next period
    // LOCKED | at least one valid period accepted
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MIN     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             d;
    logic             rise;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign rise = s2 & ~d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            alive        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            glitch       <= 1'b0;
            edge_count   <= 8'd0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            glitch       <= 1'b0;

            if (rise) begin
                edge_count <= edge_count + 8'd1;
                cnt        <= CNT_ONE;
                case (state)
                    IDLE: state <= ARMED;
                    ARMED, LOCKED: begin
                        // a rise coinciding with the timeout count still wins
                        if (cnt >= CNT_MIN) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            alive        <= 1'b1;
                            state        <= LOCKED;
                        end else begin
                            glitch <= 1'b1;
                            alive  <= 1'b0;
                            state  <= ARMED;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: cnt <= '0;
                    ARMED, LOCKED: begin
                        if (cnt >= CNT_TIMEOUT) begin
                            timeout <= 1'b1;
                            alive   <= 1'b0;
                            state   <= IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: directed scenarios plus random pulse trains,
// checked every cycle against a rise-time based reference model.
module tb_heartbeat_monitor;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 100;
    localparam int MIN_PERIOD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             alive;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             glitch;
    logic [7:0]       edge_count;

    int n_chk = 0;
    int n_bad = 0;

    heartbeat_monitor #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .alive        (alive),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .glitch       (glitch),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: sig_in as sampled on each clock edge since reset; a rise
    // takes effect three edges after the first high sample, and the period is
    // simply the distance in edges between successive effective rises.
    bit hist[$];
    bit have_ref;
    int ref_k;
    bit m_alive;
    int m_period;
    bit m_pv;
    bit m_to;
    bit m_gl;
    int m_ec;
    int k;
    int el;
    bit r;

    function automatic bit hist_at(input int i);
        if (i < 0) return 1'b0;
        return hist[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            have_ref = 1'b0;
            ref_k    = 0;
            m_alive  = 1'b0;
            m_period = 0;
            m_pv     = 1'b0;
            m_to     = 1'b0;
            m_gl     = 1'b0;
            m_ec     = 0;
        end else begin
            k = hist.size();
            hist.push_back(sig_in);
            r = hist_at(k - 2) && !hist_at(k - 3);
            el = k - ref_k;
            m_pv = 1'b0;
            m_to = 1'b0;
            m_gl = 1'b0;
            if (r) begin
                m_ec = (m_ec + 1) % 256;
                if (have_ref) begin
                    if (el >= MIN_PERIOD) begin
                        m_period = el;
                        m_pv     = 1'b1;
                        m_alive  = 1'b1;
                    end else begin
                        m_gl    = 1'b1;
                        m_alive = 1'b0;
                    end
                end
                have_ref = 1'b1;
                ref_k    = k;
            end else if (have_ref && el >= TIMEOUT) begin
                m_to     = 1'b1;
                m_alive  = 1'b0;
                have_ref = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_val("alive",        32'(alive),        32'(m_alive));
            check_val("period",       32'(period),       32'(m_period));
            check_val("period_valid", 32'(period_valid), 32'(m_pv));
            check_val("timeout",      32'(timeout),      32'(m_to));
            check_val("glitch",       32'(glitch),       32'(m_gl));
            check_val("edge_count",   32'(edge_count),   32'(m_ec));
        end
    end

    // Starts and ends on a falling clock edge; rises are exactly per cycles apart.
    task automatic pulse(input int per, input int hi);
        sig_in = 1'b1;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_alive"},  32'(alive),        32'd0);
        check_val({tag, "_period"}, 32'(period),       32'd0);
        check_val({tag, "_pv"},     32'(period_valid), 32'd0);
        check_val({tag, "_to"},     32'(timeout),      32'd0);
        check_val({tag, "_gl"},     32'(glitch),       32'd0);
        check_val({tag, "_ec"},     32'(edge_count),   32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int per;
        sig_in = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        do_reset();

        // 20-cycle square wave after a random idle gap
        repeat ($urandom_range(1, 7)) @(negedge clk);
        for (int i = 0; i < 8; i++) pulse(20, $urandom_range(1, 19));
        check_val("t1_period", 32'(period), 32'd20);
        check_val("t1_alive",  32'(alive),  32'd1);

        // link goes quiet
        repeat (130) @(negedge clk);
        check_val("t2_period", 32'(period), 32'd20);
        check_val("t2_alive",  32'(alive),  32'd0);

        // relock, then glitch rises 2 cycles apart, then clean again
        for (int i = 0; i < 3; i++) pulse(20, 10);
        pulse(2, 1);
        pulse(2, 1);
        pulse(20, 10);
        pulse(20, 10);
        check_val("t3_period", 32'(period), 32'd20);
        check_val("t3_alive",  32'(alive),  32'd1);

        // rises exactly TIMEOUT apart, then TIMEOUT+1 apart
        for (int i = 0; i < 3; i++) pulse(20, 3);
        pulse(100, 3);
        pulse(101, 3);
        check_val("t4_period100", 32'(period), 32'd100);
        pulse(20, 3);
        check_val("t4_period_hold", 32'(period), 32'd100);
        check_val("t4_alive",       32'(alive),  32'd0);
        for (int i = 0; i < 3; i++) pulse(20, 3);

        // asynchronous reset mid-period while locked
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        sig_in = 1'b0;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(20, 8);
        pulse(20, 8);
        check_val("t5_relock_alive",  32'(alive),  32'd1);
        check_val("t5_relock_period", 32'(period), 32'd20);

        // edge_count wrap
        do_reset();
        for (int i = 0; i < 257; i++) pulse(8, 4);
        repeat (4) @(negedge clk);
        check_val("t6_edge_wrap", 32'(edge_count), 32'd1);
        check_val("t6_alive",     32'(alive),      32'd1);
        check_val("t6_period",    32'(period),     32'd8);

        // random trains covering glitches, near-timeout and timeout spacings
        for (int i = 0; i < 80; i++) begin
            per = $urandom_range(1, 115);
            pulse(per, $urandom_range(1, per));
        end
        repeat (120) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/heartbeat_monitor.md
Name: heartbeat_monitor

Overview:
- Receive-side counterpart to the heartbeat generator.
- Samples a heartbeat square wave from an input pad, for example a cell's hsig_Y pad input, through a 2-FF synchronizer.
- Measures the period between rising edges in clk cycles.
- Flags the link alive, timed out or glitched, so a cell macro can verify a neighbouring heartbeat on silicon.

Parameters:
- CNT_W, 16: width of the period counter and the period output. Must hold TIMEOUT.
- TIMEOUT, 50000: cycles without a rising edge before the link is declared dead. Range 2..2^CNT_W-1.
- MIN_PERIOD, 4: shortest accepted period in cycles. Shorter periods are glitches. Range 2..TIMEOUT.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  raw heartbeat from the pad, asynchronous to clk.
- alive  output  1  high while a valid heartbeat is locked.
- period  output  CNT_W  last accepted period in cycles. Holds its value between updates.
- period_valid  output  1  one-cycle pulse when period updates.
- timeout  output  1  one-cycle pulse when the link is declared dead.
- glitch  output  1  one-cycle pulse when a rise arrives with period < MIN_PERIOD.
- edge_count  output  8  count of synchronized rising edges, including glitches. Wraps 255->0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - Synchronizer flops s1, s2 and delay flop d are 0.
  - cnt is 0 and state is IDLE.
  - Reset mid-operation abandons any measurement immediately. No pulse is emitted on reset exit.
- Synchronizer: s1<=sig_in, s2<=s1, d<=s2.
- rise = s2 & ~d, combinational.
  - If sig_in goes high before edge N, rise is high in the cycle after edge N+1.
  - Events caused by that rise are registered at edge N+2.
- sig_in pulses shorter than one clk period may be missed. This is not an error.
- All outputs are registered.
- States: IDLE (no reference edge), ARMED (one reference edge, measuring), LOCKED (at least one valid period).
- Counter rules:
  - On rise: cnt<=1.
  - Else in IDLE: cnt holds at 0.
  - Else: cnt<=cnt+1, never exceeding TIMEOUT (see timeout).
- Period measured on a rise = cnt. Example: rise pulses 10 cycles apart give period=10.
- IDLE:
  - On rise -> ARMED, cnt<=1.
  - No timeout in IDLE.
- ARMED or LOCKED, on rise:
  - If cnt >= MIN_PERIOD: period<=cnt, period_valid<=1, alive<=1, state->LOCKED.
  - If cnt < MIN_PERIOD: glitch<=1, alive<=0, state->ARMED. period is unchanged and there is no period_valid.
- ARMED or LOCKED, no rise, cnt==TIMEOUT:
  - timeout<=1, alive<=0, state->IDLE, cnt<=0.
- Rise in the same cycle as cnt==TIMEOUT: the rise wins. The period is accepted as TIMEOUT and no timeout pulse is emitted.
- alive rises only on a period_valid cycle. It falls only on glitch, timeout or reset.
- edge_count increments on every rise in any state, modulo 256.
- period_valid, timeout and glitch are mutually exclusive and never high for two consecutive cycles from the same event.
- No other states. Any unreachable encoding recovers to IDLE.

Test Plan:
Bench uses TIMEOUT=100 and MIN_PERIOD=4 unless noted.
1. Reset, then a 20-cycle square wave on sig_in -> first period_valid with period=20 two rises after start; alive=1 from then on; period_valid every 20 cycles; edge_count increments per rise.
2. Lock on a 20-cycle wave, then hold sig_in low -> exactly 100 cycles after the last rise pulse: timeout pulses once, alive=0, period keeps 20; no further pulses.
3. Locked at period 20, then inject extra rises 2 cycles apart -> glitch pulse, alive=0, period stays 20; next clean 20-cycle period -> period_valid, alive=1.
4. Rises exactly TIMEOUT=100 cycles apart -> period=100 accepted, no timeout pulse. 101 cycles apart -> timeout, then re-arm on the late rise; no period_valid for that interval.
5. Assert rst_n low mid-period while locked -> all outputs 0 immediately (asynchronous). After release, a 20-cycle wave relocks within two rises.
6. 257 rises at period 8 -> edge_count wraps to 1; alive stays 1 throughout.
